seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
//  Receive-side monitor for the multiplexed 7-segment bus (AN, CA-CG, DP).
//  Samples the active-low anode/segment lines, waits for each digit to settle,
//  decodes the segment pattern back to a hex nibble and holds one nibble per digit.
//  Used for loopback/self-check of display drivers and for board-level debug via LEDs.
// PARAMETERS
//  NUM_DIGITS     8          digits on the bus; width of AN
//  STABLE_CYCLES  16         synced samples that must be identical before commit (>=2)
//  TIMEOUT_CYCLES 1_000_000  cycles with no commit before all DIGIT_VALID clear
// PORTS
//  CLK100MHZ   in   1              system clock, 100 MHz
//  CPU_RESETN  in   1              reset, asynchronous, active-low
//  AN          in   NUM_DIGITS     anode enables, active-low; AN[i] selects digit i
//  SEG         in   7              segments {CG,CF,CE,CD,CC,CB,CA}, active-low
//  DP          in   1              decimal point, active-low
//  DIGITS      out  4*NUM_DIGITS   decoded nibble of digit i at [4i+3:4i]
//  DIGIT_VALID out  NUM_DIGITS     1 = DIGITS slice i holds a legal decode
//  DP_OUT      out  NUM_DIGITS     DP state of digit i, active-high
//  UPDATE      out  1              1-cycle pulse on each successful commit
//  ERR         out  1              sticky: illegal pattern or >1 anode low
// BEHAVIOUR
//  Reset: all outputs 0, FSM in SETTLE, counters 0. Asynchronous assert, synchronous release.
//  Sync: AN, SEG, DP each pass through a 2-flop synchronizer; word W = {AN_s,DP_s,SEG_s}.
//  Stability: cnt counts consecutive cycles with W == W_prev, saturating at STABLE_CYCLES-1.
//   Any change in W resets cnt to 0 and forces state SETTLE.
//  FSM: SETTLE --cnt==STABLE_CYCLES-1--> COMMIT (1 cycle) --> HELD.
//   HELD --W changes--> SETTLE. Each stable window commits exactly once.
//  Commit action (registered, on the COMMIT cycle):
//   - AN_s all ones (blanking): no output change, no UPDATE, timeout not reset.
//   - exactly one AN_s bit low at i: decode ~SEG_s (gfedcba, active-high):
//     3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9 77=A 7C=b 39=C 5E=d 79=E 71=F.
//     Match: DIGITS[i]<=nibble, DIGIT_VALID[i]<=1, DP_OUT[i]<=~DP_s, UPDATE=1, timeout<=0.
//     No match: DIGIT_VALID[i]<=0, DIGITS[i] unchanged, ERR<=1, no UPDATE.
//   - two or more AN_s bits low: no output change, ERR<=1, no UPDATE.
//  Latency: input pins held constant from edge N -> outputs/UPDATE visible after edge
//   N+2+STABLE_CYCLES+1 (2 sync, STABLE_CYCLES settle, 1 commit).
//  Timeout: counter increments every cycle, cleared on each successful commit; at
//   TIMEOUT_CYCLES-1 all DIGIT_VALID <= 0 (DIGITS, DP_OUT retained), counter holds.
//  ERR clears only on reset. UPDATE never asserted two cycles in a row.
//  Reset mid-settle: pending commit discarded; after release, full STABLE_CYCLES re-required.
// TESTING
//  1 Reset with random inputs -> DIGITS=0, DIGIT_VALID=0, DP_OUT=0, UPDATE=0, ERR=0.
//  2 AN=8'hFE, SEG=~7'h5B, DP=0 held 30 cycles -> DIGITS[3:0]=2, DIGIT_VALID=8'h01,
//    DP_OUT=8'h01, exactly one UPDATE pulse at edge N+19.
//  3 Scan digits 0..7 showing 0..7, 40 cycles each, two full frames ->
//    DIGITS=32'h76543210, DIGIT_VALID=8'hFF, 8 UPDATE pulses per frame, ERR=0.
//  4 Toggle SEG every 10 cycles (<STABLE_CYCLES) for 500 cycles -> no UPDATE, outputs unchanged.
//  5 AN=8'hFC held -> ERR=1, no UPDATE; then AN=8'hFB, SEG=~7'h00 -> DIGIT_VALID[2]=0, ERR stays 1.
//  6 After test 3, AN=8'hFF for TIMEOUT_CYCLES -> DIGIT_VALID=0, DIGITS still 32'h76543210;
//    assert CPU_RESETN low mid-settle -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: multiplexed 7-segment bus plus the decoded readback of each digit
//   AN, SEG, DP                         active-low bus lines (driven by the display driver / master)
//   DIGITS, DIGIT_VALID, DP_OUT,
//   UPDATE, ERR                         decoded results (driven by the reader / slave)
interface seg7_scan_reader_if #(parameter int NUM_DIGITS = 8);
    logic [NUM_DIGITS-1:0]   AN;
    logic [6:0]              SEG;
    logic                    DP;
    logic [4*NUM_DIGITS-1:0] DIGITS;
    logic [NUM_DIGITS-1:0]   DIGIT_VALID;
    logic [NUM_DIGITS-1:0]   DP_OUT;
    logic                    UPDATE;
    logic                    ERR;
    modport master (output AN, SEG, DP, input DIGITS, DIGIT_VALID, DP_OUT, UPDATE, ERR);
    modport slave  (input AN, SEG, DP, output DIGITS, DIGIT_VALID, DP_OUT, UPDATE, ERR);
endinterface

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed 7-segment bus, waits for each digit to settle and
// decodes it back to one hex nibble per digit.
//   CLK100MHZ   system clock
//   CPU_RESETN  asynchronous active-low reset, released synchronously inside
//   bus         slave side of seg7_scan_reader_if (AN/SEG/DP in, decoded results out)
module seg7_scan_reader #(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic                CLK100MHZ,
    input logic                CPU_RESETN,
    seg7_scan_reader_if.slave  bus
);
    localparam int WW = NUM_DIGITS + 8;
    localparam int CW = STABLE_CYCLES > 2 ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {SETTLE, COMMIT, HELD} state_t;

    state_t                  state;
    logic                    rst_meta, rst_n;
    logic [WW-1:0]           w_meta, w, w_prev;
    logic [CW-1:0]           cnt;
    logic [TW-1:0]           tcnt;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   valid, dp_out, an_on;
    logic                    update, err, hit, one_hot;
    logic [6:0]              seg_on;
    logic [3:0]              nib;
    logic [AW-1:0]           idx;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
        if (!CPU_RESETN) {rst_n, rst_meta} <= 2'b00;
        else {rst_n, rst_meta} <= {rst_meta, 1'b1};

    // Decode works on w_prev: on the COMMIT cycle it is always the word of the stable window.
    assign an_on   = ~w_prev[WW-1:8];
    assign seg_on  = ~w_prev[6:0];
    assign one_hot = an_on != '0 && (an_on & (an_on - NUM_DIGITS'(1))) == '0;

    always_comb begin
        hit = 1'b0;
        nib = 4'h0;
        idx = '0;
        for (int k = 0; k < 16; k++)
            if (seg_on == PAT[k]) begin
                hit = 1'b1;
                nib = 4'(k);
            end
        for (int k = 0; k < NUM_DIGITS; k++)
            if (an_on[k]) idx = AW'(k);
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n)
        if (!rst_n) begin
            state  <= SETTLE;
            w_meta <= '0;
            w      <= '0;
            w_prev <= '0;
            cnt    <= '0;
            tcnt   <= '0;
            digits <= '0;
            valid  <= '0;
            dp_out <= '0;
            update <= 1'b0;
            err    <= 1'b0;
        end else begin
            w_meta <= {bus.AN, bus.DP, bus.SEG};
            w      <= w_meta;
            w_prev <= w;
            update <= 1'b0;
            cnt    <= (w != w_prev) ? '0 : (cnt == CMAX) ? cnt : cnt + CW'(1);
            state  <= (w != w_prev) ? SETTLE :
                      (state == SETTLE && cnt == CMAX) ? COMMIT :
                      (state == COMMIT) ? HELD : state;
            // A successful commit below overrides both the count and the clear.
            if (tcnt == TMAX) valid <= '0;
            else tcnt <= tcnt + TW'(1);
            if (state == COMMIT && one_hot) begin
                if (hit) begin
                    digits[{idx, 2'b00} +: 4] <= nib;
                    valid[idx]  <= 1'b1;
                    dp_out[idx] <= ~w_prev[7];
                    update      <= 1'b1;
                    tcnt        <= '0;
                end else begin
                    valid[idx] <= 1'b0;
                    err        <= 1'b1;
                end
            end else if (state == COMMIT && an_on != '0) begin
                err <= 1'b1;
            end
        end

    assign bus.DIGITS      = digits;
    assign bus.DIGIT_VALID = valid;
    assign bus.DP_OUT      = dp_out;
    assign bus.UPDATE      = update;
    assign bus.ERR         = err;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed, table-driven check of seg7_scan_reader
module tb_seg7_scan_reader;
    localparam int ND = 8;
    localparam int SC = 16;
    localparam int TO = 2000;

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  seg_on;
        logic        dp;
        logic [31:0] digits;
        logic [7:0]  valid;
        logic [7:0]  dpo;
        logic        err;
        int          upd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, failures = 0;
    int cyc = 0, win_k = 0, upd_cnt = 0, first_upd = -1, last_upd_cyc = 0, b2b = 0, tot;
    logic prev_upd = 1'b0;
    vec_t tbl [20];
    logic [6:0] pat [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk = ~clk;

    seg7_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (bus)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            win_k++;
            if (bus.UPDATE) begin
                if (upd_cnt == 0) first_upd = win_k - 1;
                upd_cnt++;
                last_upd_cyc = cyc;
                if (prev_upd) b2b++;
            end
            prev_upd = bus.UPDATE;
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [6:0] seg_on, input logic dp);
        bus.AN = an;
        bus.SEG = ~seg_on;
        bus.DP = dp;
        upd_cnt = 0;
        first_upd = -1;
        win_k = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{8'hFE, 7'h3F, 1'b1, 32'h00000000, 8'h01, 8'h00, 1'b0, 1};
        tbl[1]  = '{8'hFD, 7'h06, 1'b1, 32'h00000010, 8'h03, 8'h00, 1'b0, 1};
        tbl[2]  = '{8'hFB, 7'h5B, 1'b1, 32'h00000210, 8'h07, 8'h00, 1'b0, 1};
        tbl[3]  = '{8'hF7, 7'h4F, 1'b1, 32'h00003210, 8'h0F, 8'h00, 1'b0, 1};
        tbl[4]  = '{8'hEF, 7'h66, 1'b1, 32'h00043210, 8'h1F, 8'h00, 1'b0, 1};
        tbl[5]  = '{8'hDF, 7'h6D, 1'b1, 32'h00543210, 8'h3F, 8'h00, 1'b0, 1};
        tbl[6]  = '{8'hBF, 7'h7D, 1'b1, 32'h06543210, 8'h7F, 8'h00, 1'b0, 1};
        tbl[7]  = '{8'h7F, 7'h07, 1'b1, 32'h76543210, 8'hFF, 8'h00, 1'b0, 1};
        tbl[8]  = '{8'hF7, 7'h77, 1'b0, 32'h7654A210, 8'hFF, 8'h08, 1'b0, 1};
        tbl[9]  = '{8'hDF, 7'h7C, 1'b1, 32'h76B4A210, 8'hFF, 8'h08, 1'b0, 1};
        tbl[10] = '{8'h7F, 7'h39, 1'b0, 32'hC6B4A210, 8'hFF, 8'h88, 1'b0, 1};
        tbl[11] = '{8'hFE, 7'h5E, 1'b1, 32'hC6B4A21D, 8'hFF, 8'h88, 1'b0, 1};
        tbl[12] = '{8'hFD, 7'h79, 1'b0, 32'hC6B4A2ED, 8'hFF, 8'h8A, 1'b0, 1};
        tbl[13] = '{8'hBF, 7'h71, 1'b1, 32'hCFB4A2ED, 8'hFF, 8'h8A, 1'b0, 1};
        tbl[14] = '{8'hFB, 7'h7F, 1'b1, 32'hCFB4A8ED, 8'hFF, 8'h8A, 1'b0, 1};
        tbl[15] = '{8'hEF, 7'h6F, 1'b0, 32'hCFB9A8ED, 8'hFF, 8'h9A, 1'b0, 1};
        tbl[16] = '{8'hFF, 7'h00, 1'b1, 32'hCFB9A8ED, 8'hFF, 8'h9A, 1'b0, 0};
        tbl[17] = '{8'hFC, 7'h3F, 1'b0, 32'hCFB9A8ED, 8'hFF, 8'h9A, 1'b1, 0};
        tbl[18] = '{8'hFB, 7'h00, 1'b1, 32'hCFB9A8ED, 8'hFB, 8'h9A, 1'b1, 0};
        tbl[19] = '{8'hFB, 7'h06, 1'b0, 32'hCFB9A1ED, 8'hFF, 8'h9E, 1'b1, 1};

        bus.AN = 8'($urandom);
        bus.SEG = 7'($urandom);
        bus.DP = 1'($urandom);
        tick(3);
        chk("rst_digits", bus.DIGITS, 32'h0);
        chk("rst_valid", 32'(bus.DIGIT_VALID), 32'h0);
        chk("rst_dpout", 32'(bus.DP_OUT), 32'h0);
        chk("rst_update", 32'(bus.UPDATE), 32'h0);
        chk("rst_err", 32'(bus.ERR), 32'h0);
        rst_n = 1'b1;
        drive(8'hFF, 7'h00, 1'b1);
        tick(30);

        drive(8'hFE, 7'h5B, 1'b0);
        tick(30);
        chk("single_upd_count", upd_cnt, 1);
        chk("single_upd_edge", first_upd, 19);
        chk("single_digits", bus.DIGITS, 32'h00000002);
        chk("single_valid", 32'(bus.DIGIT_VALID), 32'h01);
        chk("single_dpout", 32'(bus.DP_OUT), 32'h01);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].an, tbl[i].seg_on, tbl[i].dp);
            tick(40);
            chk($sformatf("v%0d_digits", i), bus.DIGITS, tbl[i].digits);
            chk($sformatf("v%0d_valid", i), 32'(bus.DIGIT_VALID), 32'(tbl[i].valid));
            chk($sformatf("v%0d_dpout", i), 32'(bus.DP_OUT), 32'(tbl[i].dpo));
            chk($sformatf("v%0d_err", i), 32'(bus.ERR), 32'(tbl[i].err));
            chk($sformatf("v%0d_upd", i), upd_cnt, tbl[i].upd);
            if (tbl[i].upd == 1) chk($sformatf("v%0d_latency", i), first_upd, 19);
        end

        rst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(bus.ERR), 32'h0);
        chk("rst2_digits", bus.DIGITS, 32'h0);
        tick(2);
        rst_n = 1'b1;
        drive(8'hFF, 7'h00, 1'b1);
        tick(30);

        for (int f = 0; f < 2; f++) begin
            tot = 0;
            for (int i = 0; i < 8; i++) begin
                drive(~(8'h01 << i), pat[i], 1'b1);
                tick(40);
                tot += upd_cnt;
            end
            chk($sformatf("frame%0d_updates", f), tot, 8);
            chk($sformatf("frame%0d_digits", f), bus.DIGITS, 32'h76543210);
            chk($sformatf("frame%0d_valid", f), 32'(bus.DIGIT_VALID), 32'hFF);
        end
        chk("frames_err", 32'(bus.ERR), 32'h0);
        chk("frames_dpout", 32'(bus.DP_OUT), 32'h00);

        tot = 0;
        for (int t = 0; t < 50; t++) begin
            drive(8'hFE, t[0] ? 7'h06 : 7'h3F, 1'b1);
            tick(10);
            tot += upd_cnt;
        end
        chk("toggle_updates", tot, 0);
        chk("toggle_digits", bus.DIGITS, 32'h76543210);
        chk("toggle_valid", 32'(bus.DIGIT_VALID), 32'hFF);

        drive(8'hFF, 7'h00, 1'b1);
        while (cyc < last_upd_cyc + TO - 1) tick(1);
        chk("timeout_before", 32'(bus.DIGIT_VALID), 32'hFF);
        tick(1);
        chk("timeout_valid", 32'(bus.DIGIT_VALID), 32'h00);
        chk("timeout_digits", bus.DIGITS, 32'h76543210);
        chk("timeout_blank_upd", upd_cnt, 0);
        tick(5);
        chk("timeout_hold", 32'(bus.DIGIT_VALID), 32'h00);

        drive(8'hFE, 7'h06, 1'b1);
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("midrst_digits", bus.DIGITS, 32'h0);
        chk("midrst_valid", 32'(bus.DIGIT_VALID), 32'h0);
        chk("midrst_dpout", 32'(bus.DP_OUT), 32'h0);
        chk("midrst_update", 32'(bus.UPDATE), 32'h0);
        chk("midrst_err", 32'(bus.ERR), 32'h0);
        tick(2);
        rst_n = 1'b1;
        drive(8'hFE, 7'h06, 1'b1);
        tick(40);
        chk("midrst_resettle", 32'(first_upd >= 19), 32'h1);
        chk("midrst_upd", upd_cnt, 1);
        chk("midrst_new_digits", bus.DIGITS, 32'h00000001);
        chk("midrst_new_valid", 32'(bus.DIGIT_VALID), 32'h01);
        chk("no_back_to_back", b2b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
